// File: rtl/seq_chunk_packer.sv
// seq_chunk_packer: packs a serial 2-bit nucleotide stream into double-buffered, request-released chunks.
// Optional SEQ_PACKER_STATS_EN adds a saturating base_count output.
module seq_chunk_packer #(
    parameter int PE_ARRAY_SIZE = 8,
    parameter int CNT_W = $clog2(PE_ARRAY_SIZE + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 in_base,
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       in_ready,
    input  logic                       request,
    output logic [2*PE_ARRAY_SIZE-1:0] chunk,
    output logic [PE_ARRAY_SIZE-1:0]   chunk_valid,
    output logic                       chunk_last
`ifdef SEQ_PACKER_STATS_EN
    ,
    output logic [31:0]                base_count
`endif
);
    logic [2*PE_ARRAY_SIZE-1:0] fillData, holdData;
    logic [PE_ARRAY_SIZE-1:0]   fillMask, holdMask;
    logic [CNT_W-1:0]           fcnt;
    logic                       fclosed, fillLast, holdLast, holdFull, pend;
    logic                       accept, delivering, moveFill;

    assign in_ready   = !fclosed;
    assign accept     = in_valid && !fclosed;
    assign delivering = (request || pend) && holdFull;
    assign moveFill   = fclosed && (!holdFull || delivering);
    // fcnt already counts the stored lanes once the fill is closed
    assign fillMask   = PE_ARRAY_SIZE'(((PE_ARRAY_SIZE + 1)'(1) << fcnt) - (PE_ARRAY_SIZE + 1)'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fillData    <= '0;
            fcnt        <= '0;
            fclosed     <= 1'b0;
            fillLast    <= 1'b0;
            holdData    <= '0;
            holdMask    <= '0;
            holdLast    <= 1'b0;
            holdFull    <= 1'b0;
            pend        <= 1'b0;
            chunk       <= '0;
            chunk_valid <= '0;
            chunk_last  <= 1'b0;
        end else begin
            if (accept) begin
                fillData[2*int'(fcnt) +: 2] <= in_base;
                fcnt                        <= fcnt + CNT_W'(1);
                fillLast                    <= in_last;
                if (fcnt == CNT_W'(PE_ARRAY_SIZE - 1) || in_last) fclosed <= 1'b1;
            end else if (moveFill) begin
                fillData <= '0;
                fcnt     <= '0;
                fclosed  <= 1'b0;
                fillLast <= 1'b0;
            end
            if (moveFill) begin
                holdData <= fillData;
                holdMask <= fillMask;
                holdLast <= fillLast;
            end
            holdFull    <= moveFill || (holdFull && !delivering);
            pend        <= !delivering && (pend || request);
            chunk_valid <= delivering ? holdMask : '0;
            chunk_last  <= delivering && holdLast;
            if (delivering) chunk <= holdData;
        end
    end

`ifdef SEQ_PACKER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) base_count <= '0;
        else if (chunk_last) base_count <= {31'd0, accept};
        else if (accept && base_count != '1) base_count <= base_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_seq_chunk_packer.sv
// tb_seq_chunk_packer: directed and randomized checks of seq_chunk_packer against a queue-based reference model.
module tb_seq_chunk_packer;
    localparam int P = 8;
    typedef struct {
        logic [2*P-1:0] d;
        logic [P-1:0]   m;
        logic           l;
    } chunkT;

    logic           clk = 0, rst = 1;
    logic [1:0]     in_base = 0;
    logic           in_valid = 0, in_last = 0, request = 0;
    logic           in_ready;
    logic [2*P-1:0] chunk;
    logic [P-1:0]   chunk_valid;
    logic           chunk_last;
`ifdef SEQ_PACKER_STATS_EN
    logic [31:0]    base_count;
`endif
    int checks = 0, failures = 0;

    seq_chunk_packer #(.PE_ARRAY_SIZE(P)) dut (
        .clk(clk), .rst(rst), .in_base(in_base), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .request(request), .chunk(chunk), .chunk_valid(chunk_valid),
        .chunk_last(chunk_last)
`ifdef SEQ_PACKER_STATS_EN
        , .base_count(base_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: bases collect in a list, closed chunks queue for delivery
    int       fillQ[$];
    chunkT    holdQ[$];
    chunkT    c;
    logic     mClosed = 0, mPend = 0, mLast = 0, dlv, mv, prevLast;
    logic [2*P-1:0] expChunk = 0;
    logic [P-1:0]   expValid = 0;
    logic           expLast = 0;
    logic [31:0]    mCount = 0;

    function automatic chunkT makeChunk();
        chunkT r;
        r.d = '0;
        r.m = '0;
        foreach (fillQ[i]) begin
            r.d[2*i +: 2] = 2'(fillQ[i]);
            r.m[i] = 1'b1;
        end
        r.l = mLast;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fillQ.delete();
            holdQ.delete();
            mClosed = 0; mPend = 0; mLast = 0;
            expChunk = 0; expValid = 0; expLast = 0; mCount = 0;
        end else begin
            dlv = (request || mPend) && holdQ.size() > 0;
            mv = mClosed && (holdQ.size() == 0 || dlv);
            prevLast = expLast;
            if (prevLast) mCount = {31'd0, in_valid && !mClosed};
            else if (in_valid && !mClosed && mCount != 32'hFFFFFFFF) mCount++;
            expValid = 0;
            expLast = 0;
            if (dlv) begin
                c = holdQ.pop_front();
                expChunk = c.d; expValid = c.m; expLast = c.l; mPend = 0;
            end else if (request) mPend = 1;
            if (mv) begin
                holdQ.push_back(makeChunk());
                fillQ.delete();
                mClosed = 0;
            end else if (in_valid && !mClosed) begin
                fillQ.push_back(int'(in_base));
                mLast = in_last;
                if (fillQ.size() == P || in_last) mClosed = 1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("in_ready", 32'(in_ready), 32'(!mClosed));
        check("chunk_valid", 32'(chunk_valid), 32'(expValid));
        check("chunk_last", 32'(chunk_last), 32'(expLast));
        check("chunk", 32'(chunk), 32'(expChunk));
`ifdef SEQ_PACKER_STATS_EN
        check("base_count", base_count, mCount);
`endif
    end

    task automatic cyc(input logic v, input logic [1:0] b, input logic l, input logic r);
        @(negedge clk);
        in_valid = v; in_base = b; in_last = l; request = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    task automatic sendBase(input logic [1:0] b, input logic l);
        logic acc;
        cyc(1, b, l, 0);
        for (int k = 0; k < 50; k++) begin
            acc = in_ready;
            @(posedge clk);
            if (acc) return;
            @(negedge clk);
        end
        check("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic after(); @(posedge clk); #2; endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 0;
        after();
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_valid", 32'(chunk_valid), 32'd0);
        // full chunk 0,1,2,3,...
        for (int i = 0; i < 8; i++) sendBase(2'(i % 4), 0);
        idle(2);
        cyc(0, 0, 0, 1);
        after();
        check("t1_chunk", 32'(chunk), 32'hE4E4);
        check("t1_valid", 32'(chunk_valid), 32'hFF);
        check("t1_last", 32'(chunk_last), 32'd0);
        idle(1);
        after();
        check("t1_valid_drop", 32'(chunk_valid), 32'd0);
        check("t1_hold", 32'(chunk), 32'hE4E4);
        // partial last chunk
        sendBase(3, 0); sendBase(3, 0); sendBase(1, 1);
        idle(2);
        cyc(0, 0, 0, 1);
        after();
        check("t2_chunk", 32'(chunk), 32'h001F);
        check("t2_valid", 32'(chunk_valid), 32'h07);
        check("t2_last", 32'(chunk_last), 32'd1);
        idle(1);
        after();
        check("t2_last_drop", 32'(chunk_last), 32'd0);
        // request before data
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 8; i++) sendBase(2'($urandom_range(0, 3)), 0);
        cyc(0, 0, 0, 0);
        after();
        check("t3_e1", 32'(chunk_valid), 32'd0);
        cyc(0, 0, 0, 0);
        after();
        check("t3_e2", 32'(chunk_valid), 32'hFF);
        // both buffers fill, then three releases
        for (int i = 0; i < 16; i++) sendBase(2'($urandom_range(0, 3)), 0);
        idle(3);
        check("t4_stall", 32'(in_ready), 32'd0);
        cyc(0, 0, 0, 1);
        after();
        check("t4_rel1", 32'(chunk_valid), 32'hFF);
        for (int i = 0; i < 8; i++) sendBase(2'($urandom_range(0, 3)), 0);
        idle(2);
        cyc(0, 0, 0, 1);
        after();
        check("t4_rel2", 32'(chunk_valid), 32'hFF);
        idle(2);
        cyc(0, 0, 0, 1);
        after();
        check("t4_rel3", 32'(chunk_valid), 32'hFF);
        idle(3);
        // async reset mid-fill with a pending request
        for (int i = 0; i < 5; i++) sendBase(2'($urandom_range(0, 3)), 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        #1 rst = 1;
        #1;
        check("t5_ready", 32'(in_ready), 32'd1);
        check("t5_chunk", 32'(chunk), 32'd0);
        check("t5_valid", 32'(chunk_valid), 32'd0);
        check("t5_last", 32'(chunk_last), 32'd0);
        @(negedge clk);
        rst = 0;
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            after();
            check("t5_nodeliv", 32'(chunk_valid), 32'd0);
        end
        // randomized traffic
        for (int i = 0; i < 3000; i++)
            cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
